snd_buffer_reader: RTL and testbench

SND_BUFFER_READER -- requirements
Module: SndBufferReader

---
 rtl/snd_buffer_reader_if.sv | 41 ++++
 rtl/snd_buffer_reader.sv | 167 ++++++++++++++++
 tb/tb_snd_buffer_reader.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snd_buffer_reader_if.sv
// AXI4 read-address and read-data channels between the send-buffer reader and DDR.
// The master modport is the reader's side of the bus.
interface snd_buffer_reader_if #(
   parameter int unsigned C_S_AXI_ID_WIDTH   = 4,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 512,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 32
);
   logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid;
   logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr;
   logic [7:0]                    s_axi_arlen;
   logic [2:0]                    s_axi_arsize;
   logic [1:0]                    s_axi_arburst;
   logic                          s_axi_arlock;
   logic [3:0]                    s_axi_arcache;
   logic [2:0]                    s_axi_arprot;
   logic [3:0]                    s_axi_arqos;
   logic                          s_axi_arvalid;
   logic                          s_axi_arready;
   logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid;
   logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata;
   logic [1:0]                    s_axi_rresp;
   logic                          s_axi_rlast;
   logic                          s_axi_rvalid;
   logic                          s_axi_rready;

   modport master (
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
      output s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready
   );

   modport slave (
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
      input  s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready
   );
endinterface

// File: rtl/snd_buffer_reader.sv
// Reads a packet out of a circular DDR send buffer with AXI4 bursts and streams it out,
// splitting bursts at the 64-beat limit and at the buffer end (where the address wraps).
module snd_buffer_reader #(
   parameter int unsigned C_S_AXI_ID_WIDTH      = 4,
   parameter int unsigned C_S_AXI_DATA_WIDTH    = 512,
   parameter int unsigned C_S_AXI_ADDR_WIDTH    = 32,
   parameter logic [31:0] SndBuffer_START       = 32'h0,
   parameter logic [31:0] SndBuffer_MAX_OFFESET = 32'h1000
) (
   input  logic                            core_clk,
   input  logic                            core_rst_n,
   input  logic [31:0]                     req_offset_i,
   input  logic [15:0]                     req_len_i,
   input  logic                            req_valid_i,
   output logic                            req_ready_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   snd_tdata_o,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0] snd_tkeep_o,
   output logic                            snd_tlast_o,
   output logic                            snd_tvalid_o,
   input  logic                            snd_tready_i,
   output logic                            rd_err_o,
   input  logic                            init_calib_complete,
   snd_buffer_reader_if.master             axi
);

   localparam int unsigned KeepW     = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned BeatShift = $clog2(KeepW);
   localparam logic [31:0] OffMask   = (SndBuffer_MAX_OFFESET - 32'd1) & ~32'(KeepW - 1);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e                        state_q, state_d;
   logic [31:0]                   off_q, off_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]                    arlen_q, arlen_d;
   logic [10:0]                   rem_q, rem_d;
   logic [10:0]                   burst_left_q, burst_left_d;
   logic [BeatShift-1:0]          tail_q, tail_d;
   logic                          err_q, err_d;

   logic        accept, beat, last_beat, load;
   logic [31:0] new_off;
   logic [10:0] new_burst, beats;
   logic        unused_rsp;

   // Largest burst that fits the remaining beats, the AXI limit and the space before the end.
   function automatic logic [10:0] calc_burst(input logic [31:0] off, input logic [10:0] rem);
      logic [31:0] room;
      logic [10:0] b;
      room = (SndBuffer_MAX_OFFESET - off) >> BeatShift;
      b = rem;
      if (b > 11'd64) b = 11'd64;
      if (32'(b) > room) b = room[10:0];
      return b;
   endfunction

   assign accept    = (state_q == StIdle) && req_valid_i && req_ready_o;
   assign beat      = (state_q == StData) && axi.s_axi_rvalid && snd_tready_i;
   assign last_beat = (rem_q == 11'd1);

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      rem_d        = rem_q;
      burst_left_d = burst_left_q;
      tail_d       = tail_q;
      err_d        = err_q;
      load         = 1'b0;
      new_off      = '0;
      new_burst    = '0;
      beats        = '0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               err_d = 1'b0;
               if (req_len_i != 16'd0) begin
                  beats     = 11'(({1'b0, req_len_i} + 17'(KeepW - 1)) >> BeatShift);
                  new_off   = req_offset_i & OffMask;
                  new_burst = calc_burst(new_off, beats);
                  rem_d     = beats;
                  tail_d    = req_len_i[BeatShift-1:0];
                  load      = 1'b1;
               end
            end
         end
         StAddr: begin
            if (axi.s_axi_arready) state_d = StData;
         end
         StData: begin
            if (beat) begin
               rem_d        = rem_q - 11'd1;
               burst_left_d = burst_left_q - 11'd1;
               if (axi.s_axi_rresp != 2'b00) err_d = 1'b1;
               if (burst_left_q == 11'd1) begin
                  if (last_beat) begin
                     state_d = StIdle;
                  end else begin
                     new_off   = (off_q + ((32'(arlen_q) + 32'd1) << BeatShift))
                                 & (SndBuffer_MAX_OFFESET - 32'd1);
                     new_burst = calc_burst(new_off, rem_q - 11'd1);
                     load      = 1'b1;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         off_d        = new_off;
         araddr_d     = C_S_AXI_ADDR_WIDTH'(SndBuffer_START + new_off);
         arlen_d      = 8'(new_burst - 11'd1);
         burst_left_d = new_burst;
         state_d      = StAddr;
      end
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state_q      <= StIdle;
         off_q        <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         rem_q        <= '0;
         burst_left_q <= '0;
         tail_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         rem_q        <= rem_d;
         burst_left_q <= burst_left_d;
         tail_q       <= tail_d;
         err_q        <= err_d;
      end
   end

   // Gated by reset so ready is low while reset is held even with calibration done.
   assign req_ready_o = core_rst_n && (state_q == StIdle) && init_calib_complete;

   assign axi.s_axi_arid    = '0;
   assign axi.s_axi_araddr  = araddr_q;
   assign axi.s_axi_arlen   = arlen_q;
   assign axi.s_axi_arsize  = 3'b110;
   assign axi.s_axi_arburst = 2'b01;
   assign axi.s_axi_arlock  = 1'b0;
   assign axi.s_axi_arcache = 4'b0011;
   assign axi.s_axi_arprot  = 3'b000;
   assign axi.s_axi_arqos   = 4'b0000;
   assign axi.s_axi_arvalid = (state_q == StAddr);
   assign axi.s_axi_rready  = (state_q == StData) && snd_tready_i;

   assign snd_tdata_o  = axi.s_axi_rdata;
   assign snd_tvalid_o = (state_q == StData) && axi.s_axi_rvalid;
   // Packet end comes from the beat count; rlast of intermediate bursts is ignored.
   assign snd_tlast_o  = snd_tvalid_o && last_beat;
   assign snd_tkeep_o  = (last_beat && (tail_q != '0)) ? ~({KeepW{1'b1}} << tail_q)
                                                        : {KeepW{1'b1}};
   assign rd_err_o     = err_q;

   assign unused_rsp = ^{axi.s_axi_rid, axi.s_axi_rlast};

endmodule

// File: tb/tb_snd_buffer_reader.sv
// Directed bench for snd_buffer_reader: a table of packet requests checked against
// hand-computed AR sequences and stream beats, plus reset/error/backpressure sequences.
module tb_snd_buffer_reader;

   logic         core_clk = 1'b0;
   logic         core_rst_n;
   logic [31:0]  req_offset_i;
   logic [15:0]  req_len_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [511:0] snd_tdata_o;
   logic [63:0]  snd_tkeep_o;
   logic         snd_tlast_o;
   logic         snd_tvalid_o;
   logic         snd_tready_i;
   logic         rd_err_o;
   logic         init_calib_complete;

   always #5 core_clk = ~core_clk;

   snd_buffer_reader_if #(
      .C_S_AXI_ID_WIDTH   (4),
      .C_S_AXI_DATA_WIDTH (512),
      .C_S_AXI_ADDR_WIDTH (32)
   ) axi ();

   snd_buffer_reader #(
      .C_S_AXI_ID_WIDTH      (4),
      .C_S_AXI_DATA_WIDTH    (512),
      .C_S_AXI_ADDR_WIDTH    (32),
      .SndBuffer_START       (32'h0),
      .SndBuffer_MAX_OFFESET (32'h1000)
   ) dut (
      .core_clk            (core_clk),
      .core_rst_n          (core_rst_n),
      .req_offset_i        (req_offset_i),
      .req_len_i           (req_len_i),
      .req_valid_i         (req_valid_i),
      .req_ready_o         (req_ready_o),
      .snd_tdata_o         (snd_tdata_o),
      .snd_tkeep_o         (snd_tkeep_o),
      .snd_tlast_o         (snd_tlast_o),
      .snd_tvalid_o        (snd_tvalid_o),
      .snd_tready_i        (snd_tready_i),
      .rd_err_o            (rd_err_o),
      .init_calib_complete (init_calib_complete),
      .axi                 (axi)
   );

   typedef struct {
      logic [31:0] off;
      logic [15:0] len;
      int          nar;
      logic [31:0] a0;
      logic [7:0]  l0;
      logic [31:0] a1;
      logic [7:0]  l1;
      int          beats;
      logic [63:0] lkeep;
   } vec_t;

   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic         last;
   } beat_t;

   int checks   = 0;
   int failures = 0;

   logic [31:0] ar_addr_q[$];
   logic [7:0]  ar_len_q[$];
   beat_t       beat_q[$];
   int          ar_unstable, rtrack_bad;

   // Memory-model controls, written by the main sequence
   int  err_idx      = -1;
   bit  tready_toggle = 1'b0;
   bit  slave_flush   = 1'b0;
   int  slave_beat_no = 0;

   // Memory-model state, private to the model process
   logic        ar_hs, r_hs, ar_seen, hold_valid;
   logic [31:0] hold_addr, cur_addr;
   logic [7:0]  hold_len;
   int          beats_left;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // AXI read slave and stream monitor: sample at negedge, drive 1 time unit after posedge
   initial begin
      axi.s_axi_arready = 1'b0;
      axi.s_axi_rvalid  = 1'b0;
      axi.s_axi_rdata   = '0;
      axi.s_axi_rresp   = 2'b00;
      axi.s_axi_rlast   = 1'b0;
      axi.s_axi_rid     = '0;
      snd_tready_i      = 1'b1;
      beats_left        = 0;
      cur_addr          = '0;
      hold_valid        = 1'b0;
      hold_addr         = '0;
      hold_len          = '0;
      forever begin
         @(negedge core_clk);
         ar_hs   = axi.s_axi_arvalid && axi.s_axi_arready;
         r_hs    = axi.s_axi_rvalid && axi.s_axi_rready;
         ar_seen = axi.s_axi_arvalid;
         if (axi.s_axi_arvalid) begin
            if (hold_valid && (axi.s_axi_araddr !== hold_addr || axi.s_axi_arlen !== hold_len))
               ar_unstable++;
            hold_valid = !ar_hs;
            hold_addr  = axi.s_axi_araddr;
            hold_len   = axi.s_axi_arlen;
         end else begin
            hold_valid = 1'b0;
         end
         if (ar_hs) begin
            ar_addr_q.push_back(axi.s_axi_araddr);
            ar_len_q.push_back(axi.s_axi_arlen);
         end
         if (snd_tvalid_o && (axi.s_axi_rready !== snd_tready_i)) rtrack_bad++;
         if (snd_tvalid_o && snd_tready_i)
            beat_q.push_back('{data: snd_tdata_o, keep: snd_tkeep_o, last: snd_tlast_o});
         @(posedge core_clk);
         #1;
         if (slave_flush) begin
            beats_left        = 0;
            axi.s_axi_arready = 1'b0;
            axi.s_axi_rvalid  = 1'b0;
            axi.s_axi_rlast   = 1'b0;
         end else begin
            if (ar_hs) begin
               cur_addr   = axi.s_axi_araddr;
               beats_left = int'(axi.s_axi_arlen) + 1;
            end
            if (r_hs) begin
               cur_addr = cur_addr + 32'd64;
               beats_left--;
               slave_beat_no++;
            end
            axi.s_axi_arready = ar_seen && !ar_hs && (beats_left == 0);
            axi.s_axi_rvalid  = (beats_left > 0);
            axi.s_axi_rdata   = {16{cur_addr}};
            axi.s_axi_rlast   = (beats_left == 1);
            axi.s_axi_rresp   = (slave_beat_no == err_idx) ? 2'b10 : 2'b00;
         end
         snd_tready_i = tready_toggle ? !snd_tready_i : 1'b1;
      end
   end

   task automatic clear_logs();
      ar_addr_q.delete();
      ar_len_q.delete();
      beat_q.delete();
      ar_unstable   = 0;
      rtrack_bad    = 0;
      slave_beat_no = 0;
   endtask

   task automatic issue_req(input logic [31:0] off, input logic [15:0] len);
      int n = 0;
      while (!req_ready_o && n < 200) begin
         @(posedge core_clk);
         #1;
         n++;
      end
      check("req_ready_wait", 64'(req_ready_o), 64'd1);
      req_offset_i = off;
      req_len_i    = len;
      req_valid_i  = 1'b1;
      @(posedge core_clk);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic run_req(input logic [31:0] off, input logic [15:0] len, input int exp_beats);
      int n = 0;
      clear_logs();
      issue_req(off, len);
      while (beat_q.size() < exp_beats && n < 4000) begin
         @(posedge core_clk);
         #1;
         n++;
      end
      check("done_in_time", 64'(n >= 4000), 64'd0);
      repeat (10) @(posedge core_clk);
      #1;
   endtask

   task automatic check_packet(input vec_t v);
      int          bad = 0;
      logic [31:0] base, exp_addr;
      logic [63:0] exp_keep;
      check("ar_count", 64'(ar_addr_q.size()), 64'(v.nar));
      check("ar0_addr", 64'((ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hFFFF_FFFF), 64'(v.a0));
      check("ar0_len", 64'((ar_len_q.size() > 0) ? ar_len_q[0] : 8'hFF), 64'(v.l0));
      if (v.nar > 1) begin
         check("ar1_addr", 64'((ar_addr_q.size() > 1) ? ar_addr_q[1] : 32'hFFFF_FFFF),
               64'(v.a1));
         check("ar1_len", 64'((ar_len_q.size() > 1) ? ar_len_q[1] : 8'hFF), 64'(v.l1));
      end
      check("beat_count", 64'(beat_q.size()), 64'(v.beats));
      base = v.off & 32'h0000_0FC0;
      foreach (beat_q[i]) begin
         exp_addr = (base + 32'(i) * 32'd64) & 32'h0000_0FFF;
         exp_keep = (i == v.beats - 1) ? v.lkeep : 64'hFFFF_FFFF_FFFF_FFFF;
         if (beat_q[i].data !== {16{exp_addr}}) bad++;
         if (beat_q[i].keep !== exp_keep) bad++;
         if (beat_q[i].last !== (i == v.beats - 1)) bad++;
      end
      check("beat_content", 64'(bad), 64'd0);
      if (beat_q.size() > 0) begin
         check("last_keep", beat_q[beat_q.size()-1].keep, v.lkeep);
         check("last_flag", 64'(beat_q[beat_q.size()-1].last), 64'd1);
      end
      check("ar_stable", 64'(ar_unstable), 64'd0);
   endtask

   vec_t vecs[9];
   vec_t v;

   initial begin
      vecs[0] = '{32'h040,  16'd100,  1, 32'h040, 8'd1,  32'h0, 8'd0,  2,   64'hF_FFFF_FFFF};
      vecs[1] = '{32'hF80,  16'd256,  2, 32'hF80, 8'd1,  32'h0, 8'd1,  4,   '1};
      vecs[2] = '{32'h000,  16'd8192, 2, 32'h000, 8'd63, 32'h0, 8'd63, 128, '1};
      vecs[3] = '{32'h07F,  16'd1,    1, 32'h040, 8'd0,  32'h0, 8'd0,  1,   64'h1};
      vecs[4] = '{32'h1FC0, 16'd64,   1, 32'hFC0, 8'd0,  32'h0, 8'd0,  1,   '1};
      vecs[5] = '{32'h100,  16'd65,   1, 32'h100, 8'd1,  32'h0, 8'd0,  2,   64'h1};
      vecs[6] = '{32'hFC0,  16'd130,  2, 32'hFC0, 8'd0,  32'h0, 8'd1,  3,   64'h3};
      vecs[7] = '{32'h000,  16'd4160, 2, 32'h000, 8'd63, 32'h0, 8'd0,  65,  '1};
      vecs[8] = '{32'h040,  16'd4096, 2, 32'h040, 8'd62, 32'h0, 8'd0,  64,  '1};

      core_rst_n          = 1'b0;
      init_calib_complete = 1'b1;
      req_offset_i        = '0;
      req_len_i           = '0;
      req_valid_i         = 1'b0;
      repeat (2) @(posedge core_clk);
      #1;
      check("rst_req_ready", 64'(req_ready_o), 64'd0);
      check("rst_arvalid", 64'(axi.s_axi_arvalid), 64'd0);
      check("rst_tvalid", 64'(snd_tvalid_o), 64'd0);
      check("rst_rd_err", 64'(rd_err_o), 64'd0);
      @(negedge core_clk);
      core_rst_n = 1'b1;
      @(posedge core_clk);
      #1;
      check("ready_after_rst", 64'(req_ready_o), 64'd1);
      init_calib_complete = 1'b0;
      #1;
      check("ready_calib_low", 64'(req_ready_o), 64'd0);
      init_calib_complete = 1'b1;
      #1;
      check("ready_calib_high", 64'(req_ready_o), 64'd1);

      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i].off, vecs[i].len, vecs[i].beats);
         check_packet(vecs[i]);
         check("rd_err_clean", 64'(rd_err_o), 64'd0);
      end

      // Backpressure: tready toggles every cycle
      tready_toggle = 1'b1;
      run_req(32'h200, 16'd128, 2);
      v = '{32'h200, 16'd128, 1, 32'h200, 8'd1, 32'h0, 8'd0, 2, '1};
      check_packet(v);
      check("rready_tracks", 64'(rtrack_bad), 64'd0);
      tready_toggle = 1'b0;
      repeat (2) @(posedge core_clk);
      #1;

      // Error response on beat 1 of 2; cleared by the next (zero-length) request
      err_idx = 0;
      run_req(32'h000, 16'd128, 2);
      err_idx = -1;
      check("err_beats", 64'(beat_q.size()), 64'd2);
      check("err_set", 64'(rd_err_o), 64'd1);
      run_req(32'h300, 16'd0, 0);
      check("len0_err_clear", 64'(rd_err_o), 64'd0);
      check("len0_no_ar", 64'(ar_addr_q.size()), 64'd0);
      check("len0_no_beat", 64'(beat_q.size()), 64'd0);
      check("len0_ready", 64'(req_ready_o), 64'd1);

      // Calibration drop mid-request must not abort it
      fork
         run_req(32'h000, 16'd8192, 128);
         begin
            repeat (30) @(posedge core_clk);
            #2;
            init_calib_complete = 1'b0;
         end
      join
      check("calib_drop_beats", 64'(beat_q.size()), 64'd128);
      check("calib_drop_ready", 64'(req_ready_o), 64'd0);
      init_calib_complete = 1'b1;
      #1;
      check("calib_back_ready", 64'(req_ready_o), 64'd1);

      // Reset in the middle of a data burst
      begin
         int n = 0;
         err_idx = 0;
         clear_logs();
         issue_req(32'h000, 16'd8192);
         while (beat_q.size() < 3 && n < 500) begin
            @(posedge core_clk);
            #1;
            n++;
         end
         check("pre_rst_beats", 64'(beat_q.size() >= 3), 64'd1);
         check("pre_rst_err", 64'(rd_err_o), 64'd1);
         err_idx     = -1;
         core_rst_n  = 1'b0;
         slave_flush = 1'b1;
         #1;
         check("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
         check("mid_rst_arvalid", 64'(axi.s_axi_arvalid), 64'd0);
         check("mid_rst_rready", 64'(axi.s_axi_rready), 64'd0);
         check("mid_rst_tvalid", 64'(snd_tvalid_o), 64'd0);
         check("mid_rst_tlast", 64'(snd_tlast_o), 64'd0);
         check("mid_rst_rd_err", 64'(rd_err_o), 64'd0);
         check("mid_rst_araddr", 64'(axi.s_axi_araddr), 64'd0);
         check("mid_rst_arlen", 64'(axi.s_axi_arlen), 64'd0);
         repeat (3) @(posedge core_clk);
         @(negedge core_clk);
         core_rst_n  = 1'b1;
         slave_flush = 1'b0;
         @(posedge core_clk);
         #1;
         check("post_rst_ready", 64'(req_ready_o), 64'd1);
      end

      run_req(vecs[0].off, vecs[0].len, vecs[0].beats);
      check_packet(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

endmodule
